// File: rtl/uart_pkg.sv
// uart_pkg: command and address widths plus command encodings shared by the
// UART debug link blocks.
//   CMDLENGTH  width of a command code
//   IRLENGTH   width of a register address
// CMDLENGTH + IRLENGTH equals 8, so that {command, address} fits in one byte.
package uart_pkg;
    localparam int CMDLENGTH = 3;
    localparam int IRLENGTH  = 5;

    localparam logic [CMDLENGTH-1:0] CMD_NOP       = 3'd0;
    localparam logic [CMDLENGTH-1:0] CMD_READ      = 3'd1;
    localparam logic [CMDLENGTH-1:0] CMD_WRITE     = 3'd2;
    localparam logic [CMDLENGTH-1:0] CMD_CONT_READ = 3'd3;
    localparam logic [CMDLENGTH-1:0] CMD_RESET     = 3'd4;
endpackage

// File: rtl/read_arbiter.sv
// read_arbiter: accepts read commands from the command decoder, fetches one
// register word and streams it LSB byte first to the UART transmitter.
// CMD_CONT_READ repeats the same read until another command arrives in the
// one-cycle gap between frames. CMD_RESET emits a one-cycle RESET_O pulse.
//
// Optional feature: define READ_ARBITER_HEADER_EN to precede every frame with
// one header byte {latched command, latched address}.
//
// Ports
//   CLK_I, RST_NI            clock, asynchronous active-low reset
//   VALID_I/READY_O          command handshake, CMD_I + ADDRESS_I
//   REG_VALID_O/REG_READY_I  register read request, REG_ADDR_O / REG_DATA_I
//   TX_VALID_O/TX_READY_I    byte stream to the transmitter, TX_DATA_O
//   RESET_O                  one-cycle debug-link reset pulse
module read_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK_I,
    input  logic                  RST_NI,
    input  logic                  VALID_I,
    output logic                  READY_O,
    input  logic [CMDLENGTH-1:0]  CMD_I,
    input  logic [IRLENGTH-1:0]   ADDRESS_I,
    output logic                  REG_VALID_O,
    input  logic                  REG_READY_I,
    output logic [IRLENGTH-1:0]   REG_ADDR_O,
    input  logic [DATA_WIDTH-1:0] REG_DATA_I,
    output logic                  TX_VALID_O,
    input  logic                  TX_READY_I,
    output logic [7:0]            TX_DATA_O,
    output logic                  RESET_O
);
    localparam int NBYTES = (DATA_WIDTH + 7) / 8;
    localparam int BUFW   = NBYTES * 8;
    localparam int IDXW   = $clog2(NBYTES + 1);

`ifdef READ_ARBITER_HEADER_EN
    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_SEND, ST_GAP, ST_HEADER} state_t;
    localparam state_t FRAME_START = ST_HEADER;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_SEND, ST_GAP} state_t;
    localparam state_t FRAME_START = ST_REQ;
`endif

    state_t               r_state, w_state_next;
    logic [CMDLENGTH-1:0] r_cmd, w_cmd_next;
    logic [IRLENGTH-1:0]  r_addr, w_addr_next;
    logic [BUFW-1:0]      r_data, w_data_next;
    logic [IDXW-1:0]      r_idx, w_idx_next;
    logic                 r_hold, w_hold_next;
    logic                 r_reset, w_reset_next;
    logic                 r_alive;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_last;
    logic [7:0]           w_byte;
    logic [BUFW-1:0]      w_data_ext;

    // Zero-pads the final byte above DATA_WIDTH.
    assign w_data_ext = BUFW'(REG_DATA_I);
    assign w_last     = (r_idx == IDXW'(NBYTES - 1));

    // r_alive keeps READY_O low until the first edge after reset release;
    // r_hold keeps it low for the cycle after any accepted command, even when
    // the command is discarded and the FSM stays in ST_IDLE.
    assign w_ready  = r_alive && !r_hold && (r_state == ST_IDLE || r_state == ST_GAP);
    assign w_accept = w_ready && VALID_I;

    always_comb begin
        w_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_byte = r_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_state <= ST_IDLE;
            r_cmd   <= CMD_NOP;
            r_addr  <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_hold  <= 1'b0;
            r_reset <= 1'b0;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cmd   <= w_cmd_next;
            r_addr  <= w_addr_next;
            r_data  <= w_data_next;
            r_idx   <= w_idx_next;
            r_hold  <= w_hold_next;
            r_reset <= w_reset_next;
            r_alive <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cmd_next   = r_cmd;
        w_addr_next  = r_addr;
        w_data_next  = r_data;
        w_idx_next   = r_idx;
        w_hold_next  = 1'b0;
        w_reset_next = 1'b0;

        if (w_accept) begin
            // Only reachable from ST_IDLE or ST_GAP; a command in the gap
            // always ends the current continuous read.
            w_hold_next = 1'b1;
            case (CMD_I)
                CMD_READ, CMD_CONT_READ: begin
                    w_cmd_next   = CMD_I;
                    w_addr_next  = ADDRESS_I;
                    w_idx_next   = '0;
                    w_state_next = FRAME_START;
                end
                CMD_RESET: begin
                    w_cmd_next   = CMD_NOP;
                    w_reset_next = 1'b1;
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end else begin
            case (r_state)
                ST_IDLE: begin
                end
                ST_GAP: begin
                    w_state_next = FRAME_START;
                end
`ifdef READ_ARBITER_HEADER_EN
                ST_HEADER: begin
                    if (TX_READY_I) begin
                        w_state_next = ST_REQ;
                    end
                end
`endif
                ST_REQ: begin
                    if (REG_READY_I) begin
                        w_data_next  = w_data_ext;
                        w_idx_next   = '0;
                        w_state_next = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (TX_READY_I) begin
                        if (w_last) begin
                            w_idx_next   = '0;
                            w_state_next = (r_cmd == CMD_CONT_READ) ? ST_GAP : ST_IDLE;
                        end else begin
                            w_idx_next = r_idx + IDXW'(1);
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        READY_O     = w_ready;
        REG_VALID_O = (r_state == ST_REQ);
        REG_ADDR_O  = r_addr;
        RESET_O     = r_reset;
        TX_VALID_O  = 1'b0;
        TX_DATA_O   = 8'h00;
        if (r_state == ST_SEND) begin
            TX_VALID_O = 1'b1;
            TX_DATA_O  = w_byte;
        end
`ifdef READ_ARBITER_HEADER_EN
        if (r_state == ST_HEADER) begin
            TX_VALID_O = 1'b1;
            TX_DATA_O  = {r_cmd, r_addr};
        end
`endif
    end
endmodule

// File: tb/tb_read_arbiter.sv
// tb_read_arbiter: directed bench for read_arbiter. Instance A uses
// DATA_WIDTH=32, instance B uses DATA_WIDTH=41. The stimulus records every
// expected register request and transmitted byte in queues; the negedge
// monitor answers register requests and compares every handshake against
// those queues. Literal checks pin reset values, latency and frame contents.
module tb_read_arbiter;
    import uart_pkg::*;

`ifdef READ_ARBITER_HEADER_EN
    localparam int HDR_BYTES = 1;
`else
    localparam int HDR_BYTES = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic                 a_valid = 1'b0, a_reg_ready = 1'b1, a_tx_ready = 1'b1;
    logic [CMDLENGTH-1:0] a_cmd = '0;
    logic [IRLENGTH-1:0]  a_addr = '0;
    logic [31:0]          a_reg_data = '0;
    logic                 a_ready, a_reg_valid, a_tx_valid, a_reset_o;
    logic [IRLENGTH-1:0]  a_reg_addr;
    logic [7:0]           a_tx_data;

    logic                 b_valid = 1'b0, b_reg_ready = 1'b1, b_tx_ready = 1'b1;
    logic [CMDLENGTH-1:0] b_cmd = '0;
    logic [IRLENGTH-1:0]  b_addr = '0;
    logic [40:0]          b_reg_data = '0;
    logic                 b_ready, b_reg_valid, b_tx_valid, b_reset_o;
    logic [IRLENGTH-1:0]  b_reg_addr;
    logic [7:0]           b_tx_data;

    read_arbiter #(.DATA_WIDTH(32)) u_dut_a (
        .CLK_I(clk), .RST_NI(rst_n), .VALID_I(a_valid), .READY_O(a_ready),
        .CMD_I(a_cmd), .ADDRESS_I(a_addr), .REG_VALID_O(a_reg_valid),
        .REG_READY_I(a_reg_ready), .REG_ADDR_O(a_reg_addr), .REG_DATA_I(a_reg_data),
        .TX_VALID_O(a_tx_valid), .TX_READY_I(a_tx_ready), .TX_DATA_O(a_tx_data),
        .RESET_O(a_reset_o)
    );

    read_arbiter #(.DATA_WIDTH(41)) u_dut_b (
        .CLK_I(clk), .RST_NI(rst_n), .VALID_I(b_valid), .READY_O(b_ready),
        .CMD_I(b_cmd), .ADDRESS_I(b_addr), .REG_VALID_O(b_reg_valid),
        .REG_READY_I(b_reg_ready), .REG_ADDR_O(b_reg_addr), .REG_DATA_I(b_reg_data),
        .TX_VALID_O(b_tx_valid), .TX_READY_I(b_tx_ready), .TX_DATA_O(b_tx_data),
        .RESET_O(b_reset_o)
    );

    // Model state: what the link must produce, in order.
    logic [7:0]          a_expq[$], b_expq[$];
    logic [IRLENGTH-1:0] a_addrq[$], b_addrq[$];
    logic [63:0]         a_rdq[$], b_rdq[$];
    logic [7:0]          a_seen[$], b_seen[$];
    int a_req_cnt = 0, b_req_cnt = 0, a_rst_pulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // One read: optional header, then ceil(w/8) data bytes LSB first with the
    // word masked to w bits.
    task automatic model_read(input int which, input logic [CMDLENGTH-1:0] cmd,
                              input logic [IRLENGTH-1:0] addr, input logic [63:0] data);
        int w, nb;
        logic [63:0] d;
        w  = (which == 0) ? 32 : 41;
        nb = (w + 7) / 8;
        d  = data & ((64'd1 << w) - 64'd1);
        for (int k = -HDR_BYTES; k < nb; k++) begin
            logic [7:0] byte_v;
            byte_v = (k < 0) ? {cmd, addr} : 8'(d >> (8 * k));
            if (which == 0) a_expq.push_back(byte_v);
            else            b_expq.push_back(byte_v);
        end
        if (which == 0) begin a_addrq.push_back(addr); a_rdq.push_back(data); end
        else            begin b_addrq.push_back(addr); b_rdq.push_back(data); end
    endtask

    // Monitor / register responder / scoreboard compare.
    logic       a_pend = 1'b0, b_pend = 1'b0;
    logic       a_ptv = 1'b0, a_ptr = 1'b0, a_prst = 1'b0, b_ptv = 1'b0, b_ptr = 1'b0;
    logic [7:0] a_ptd = '0, b_ptd = '0;

    always @(negedge clk) begin
        if (a_pend && a_rdq.size() > 0) void'(a_rdq.pop_front());
        if (b_pend && b_rdq.size() > 0) void'(b_rdq.pop_front());
        a_pend = 1'b0;
        b_pend = 1'b0;
        a_reg_data = (a_rdq.size() > 0) ? 32'(a_rdq[0]) : 32'h0;
        b_reg_data = (b_rdq.size() > 0) ? 41'(b_rdq[0]) : 41'h0;
        if (!rst_n) begin
            a_ptv = 1'b0; a_ptr = 1'b0; a_prst = 1'b0; b_ptv = 1'b0; b_ptr = 1'b0;
        end else begin
            if (a_reg_valid && a_reg_ready) begin
                a_req_cnt++;
                a_pend = 1'b1;
                if (a_addrq.size() == 0) flag("a_unexpected_req", $sformatf("addr 0x%0h, required none", a_reg_addr));
                else chk("a_reg_addr", a_reg_addr, a_addrq.pop_front());
            end
            if (b_reg_valid && b_reg_ready) begin
                b_req_cnt++;
                b_pend = 1'b1;
                if (b_addrq.size() == 0) flag("b_unexpected_req", $sformatf("addr 0x%0h, required none", b_reg_addr));
                else chk("b_reg_addr", b_reg_addr, b_addrq.pop_front());
            end
            if (a_ptv && !a_ptr) begin
                chk("a_tx_hold_valid", a_tx_valid, 1);
                chk("a_tx_hold_data", a_tx_data, a_ptd);
            end
            if (b_ptv && !b_ptr) begin
                chk("b_tx_hold_valid", b_tx_valid, 1);
                chk("b_tx_hold_data", b_tx_data, b_ptd);
            end
            if (a_tx_valid && a_tx_ready) begin
                a_seen.push_back(a_tx_data);
                if (a_expq.size() == 0) flag("a_unexpected_byte", $sformatf("byte 0x%0h, required none", a_tx_data));
                else chk("a_tx_byte", a_tx_data, a_expq.pop_front());
            end
            if (b_tx_valid && b_tx_ready) begin
                b_seen.push_back(b_tx_data);
                if (b_expq.size() == 0) flag("b_unexpected_byte", $sformatf("byte 0x%0h, required none", b_tx_data));
                else chk("b_tx_byte", b_tx_data, b_expq.pop_front());
            end
            if (a_reset_o) begin
                a_rst_pulses++;
                chk("a_reset_o_width", a_prst, 0);
            end
            a_ptv = a_tx_valid; a_ptr = a_tx_ready; a_ptd = a_tx_data; a_prst = a_reset_o;
            b_ptv = b_tx_valid; b_ptr = b_tx_ready; b_ptd = b_tx_data;
        end
    end

    // Present a command and hold it until accepted; returns 1 ns after the
    // accepting edge.
    task automatic issue(input int which, input logic [CMDLENGTH-1:0] cmd,
                         input logic [IRLENGTH-1:0] addr, input string name);
        bit ok;
        ok = 1'b0;
        if (which == 0) begin a_valid = 1'b1; a_cmd = cmd; a_addr = addr; end
        else            begin b_valid = 1'b1; b_cmd = cmd; b_addr = addr; end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((which == 0) ? a_ready : b_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_accept: not accepted within 300 cycles", name); end
    endtask

    task automatic wait_done(input int which, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (which == 0 && a_expq.size() == 0 && a_ready) begin ok = 1'b1; break; end
            if (which == 1 && b_expq.size() == 0 && b_ready) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_done: frame not finished within 400 cycles", name); end
    endtask

    function automatic logic [7:0] seen_at(input int which, input int i);
        if (which == 0) return (i < a_seen.size()) ? a_seen[i] : 8'bx;
        return (i < b_seen.size()) ? b_seen[i] : 8'bx;
    endfunction

    // Data bytes of frame fidx against a literal word, LSB first.
    task automatic check_frame(input int which, input string name, input int fidx,
                               input int n, input logic [63:0] exp);
        int base;
        base = fidx * (n + HDR_BYTES) + HDR_BYTES;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_byte%0d", name, k), seen_at(which, base + k), exp[8*k +: 8]);
        end
    endtask

    task automatic wait_tx_byte(input logic [7:0] val, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (a_tx_valid && a_tx_data == val) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL %s: byte 0x%0h never presented", name, val); end
    endtask

    initial begin
        logic [CMDLENGTH-1:0] discard_cmds [3];
        int base;
        bit ok;

        repeat (3) @(posedge clk); #1;
        chk("rst_ready", a_ready, 0);
        chk("rst_reg_valid", a_reg_valid, 0);
        chk("rst_tx_valid", a_tx_valid, 0);
        chk("rst_tx_data", a_tx_data, 0);
        chk("rst_reg_addr", a_reg_addr, 0);
        chk("rst_reset_o", a_reset_o, 0);
        chk("rst_b_ready", b_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", a_ready, 1);

        // Plain read with latency and address checks.
        a_seen.delete();
        model_read(0, CMD_READ, 5'h11, 64'hDEADBEEF);
        issue(0, CMD_READ, 5'h11, "read1");
        chk("read1_ready_low", a_ready, 0);
`ifdef READ_ARBITER_HEADER_EN
        chk("read1_hdr_valid", a_tx_valid, 1);
        chk("read1_hdr_data", a_tx_data, 8'h31);
`else
        chk("read1_reg_valid", a_reg_valid, 1);
        chk("read1_reg_addr", a_reg_addr, 5'h11);
        @(posedge clk); #1;
        chk("read1_latency_valid", a_tx_valid, 1);
        chk("read1_latency_data", a_tx_data, 8'hEF);
`endif
        wait_done(0, "read1");
        chk("read1_len", a_seen.size(), 4 + HDR_BYTES);
        check_frame(0, "read1", 0, 4, 64'hDEADBEEF);
`ifdef READ_ARBITER_HEADER_EN
        chk("read1_hdr", seen_at(0, 0), 8'h31);
`endif

        // Transmitter stall on byte 2.
        a_seen.delete();
        model_read(0, CMD_READ, 5'h11, 64'hDEADBEEF);
        issue(0, CMD_READ, 5'h11, "stall");
        wait_tx_byte(8'hAD, "stall_reach");
        a_tx_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("stall_valid", a_tx_valid, 1);
        chk("stall_data", a_tx_data, 8'hAD);
        a_tx_ready = 1'b1;
        wait_done(0, "stall");
        chk("stall_len", a_seen.size(), 4 + HDR_BYTES);
        check_frame(0, "stall", 0, 4, 64'hDEADBEEF);

        // Continuous read, two frames, ended by CMD_RESET in the gap.
        a_seen.delete();
        base = a_req_cnt;
        model_read(0, CMD_CONT_READ, 5'h10, 64'h1);
        model_read(0, CMD_CONT_READ, 5'h10, 64'h2);
        issue(0, CMD_CONT_READ, 5'h10, "cont");
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (a_req_cnt >= base + 2) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL cont_second_req: got %0d requests, required 2", a_req_cnt - base); end
        issue(0, CMD_RESET, 5'h00, "cont_stop");
        chk("cont_reset_pulse", a_reset_o, 1);
        chk("cont_stop_ready_low", a_ready, 0);
        @(posedge clk); #1;
        chk("cont_reset_pulse_end", a_reset_o, 0);
        chk("cont_ready_back", a_ready, 1);
        repeat (30) @(posedge clk); #1;
        chk("cont_len", a_seen.size(), 2 * (4 + HDR_BYTES));
        check_frame(0, "cont_f0", 0, 4, 64'h00000001);
        check_frame(0, "cont_f1", 1, 4, 64'h00000002);
`ifdef READ_ARBITER_HEADER_EN
        chk("cont_hdr", seen_at(0, 0), 8'h70);
`endif

        // Discarded commands: ready drops one cycle, nothing else happens.
        discard_cmds[0] = CMD_NOP;
        discard_cmds[1] = CMD_WRITE;
        discard_cmds[2] = '1;
        foreach (discard_cmds[j]) begin
            issue(0, discard_cmds[j], 5'h05, $sformatf("discard%0d", j));
            chk($sformatf("discard%0d_ready_low", j), a_ready, 0);
            chk($sformatf("discard%0d_reg_valid", j), a_reg_valid, 0);
            chk($sformatf("discard%0d_tx_valid", j), a_tx_valid, 0);
            @(posedge clk); #1;
            chk($sformatf("discard%0d_ready_back", j), a_ready, 1);
            chk($sformatf("discard%0d_reg_valid2", j), a_reg_valid, 0);
        end

        // Reset during byte 1 aborts the frame; a fresh frame follows.
        model_read(0, CMD_READ, 5'h11, 64'hDEADBEEF);
        issue(0, CMD_READ, 5'h11, "abort");
        wait_tx_byte(8'hBE, "abort_reach");
        rst_n = 1'b0;
        #1;
        chk("abort_tx_valid", a_tx_valid, 0);
        chk("abort_tx_data", a_tx_data, 0);
        chk("abort_ready", a_ready, 0);
        chk("abort_reg_valid", a_reg_valid, 0);
        a_expq.delete(); a_addrq.delete(); a_rdq.delete(); a_seen.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready_release", a_ready, 1);
        repeat (5) @(posedge clk); #1;
        chk("abort_no_resume", a_seen.size(), 0);
        model_read(0, CMD_READ, 5'h11, 64'hDEADBEEF);
        issue(0, CMD_READ, 5'h11, "fresh");
        wait_done(0, "fresh");
        chk("fresh_len", a_seen.size(), 4 + HDR_BYTES);
        check_frame(0, "fresh", 0, 4, 64'hDEADBEEF);

        // 41-bit word: six bytes, top byte zero-padded.
        b_seen.delete();
        model_read(1, CMD_READ, 5'h0A, 64'h1_2345_6789AB);
        issue(1, CMD_READ, 5'h0A, "w41");
        wait_done(1, "w41");
        chk("w41_len", b_seen.size(), 6 + HDR_BYTES);
        check_frame(1, "w41", 0, 6, 64'h0000_0123_4567_89AB);

        repeat (5) @(posedge clk); #1;
        chk("a_reset_pulses", a_rst_pulses, 1);
        chk("a_queue_empty", a_expq.size() + a_addrq.size(), 0);
        chk("b_queue_empty", b_expq.size() + b_addrq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
